// File: rtl/id_decode_queue.sv
// Multi-lane I-type/REGIMM decode queue: buffers fetch beats in a ring and issues
// an in-order, hazard-free prefix group into a registered valid/ready output stage.
package id_decode_pkg;
    typedef enum logic [4:0] {
        OP_INVALID = 5'd0,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_LW, OP_SW,
        OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_TEQI
    } oper_t;
endpackage

module id_lane_decode
    import id_decode_pkg::*;
(
    input  logic [31:0] inst,
    output oper_t       op,
    output logic [4:0]  raddr1,
    output logic [4:0]  raddr2,
    output logic [4:0]  waddr,
    output logic        we,
    output logic        unsigned_imm,
    output logic        is_branch,
    output logic        is_mem
);
    logic [4:0] rs, rt;
    assign rs = inst[25:21];
    assign rt = inst[20:16];

    always_comb begin
        op           = OP_INVALID;
        raddr1       = rs;
        raddr2       = 5'd0;
        waddr        = rt;
        we           = 1'b1;
        unsigned_imm = 1'b0;
        case (inst[31:26])
            6'b001000: op = OP_ADDI;
            6'b001001: op = OP_ADDIU;
            6'b001010: op = OP_SLTI;
            6'b001011: op = OP_SLTIU;
            6'b001100: begin op = OP_ANDI; unsigned_imm = 1'b1; end
            6'b001101: begin op = OP_ORI;  unsigned_imm = 1'b1; end
            6'b001110: begin op = OP_XORI; unsigned_imm = 1'b1; end
            6'b001111: begin op = OP_LUI;  unsigned_imm = 1'b1; raddr1 = 5'd0; end
            6'b000100: begin op = OP_BEQ;  raddr2 = rt; we = 1'b0; end
            6'b000101: begin op = OP_BNE;  raddr2 = rt; we = 1'b0; end
            6'b000110: begin op = OP_BLEZ; we = 1'b0; end
            6'b000111: begin op = OP_BGTZ; we = 1'b0; end
            6'b100011: begin op = OP_LW;   raddr2 = rt; end
            6'b101011: begin op = OP_SW;   raddr2 = rt; we = 1'b0; end
            6'b000001: begin
                // REGIMM: the rt field selects the operation
                case (rt)
                    5'b00000: begin op = OP_BLTZ; we = 1'b0; end
                    5'b00001: begin op = OP_BGEZ; we = 1'b0; end
                    5'b01100: begin op = OP_TEQI; we = 1'b0; end
                    5'b10000: begin op = OP_BLTZAL; waddr = 5'd31; end
                    5'b10001: begin op = OP_BGEZAL; waddr = 5'd31; end
                    default:  we = 1'b0;
                endcase
            end
            default: we = 1'b0;
        endcase
    end

    assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
                       (op == OP_BLTZ) || (op == OP_BGEZ) || (op == OP_BLTZAL) || (op == OP_BGEZAL);
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
endmodule

module id_decode_queue
    import id_decode_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    input  logic [FETCH_WIDTH*32-1:0]            in_inst,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]     in_count,
    output logic                                 in_ready,
    output logic [ISSUE_WIDTH-1:0]               out_valid,
    output oper_t [ISSUE_WIDTH-1:0]              out_op,
    output logic [ISSUE_WIDTH-1:0][4:0]          out_raddr1,
    output logic [ISSUE_WIDTH-1:0][4:0]          out_raddr2,
    output logic [ISSUE_WIDTH-1:0][4:0]          out_waddr,
    output logic [ISSUE_WIDTH-1:0]               out_we,
    output logic [ISSUE_WIDTH-1:0]               out_unsigned_imm,
    output logic [ISSUE_WIDTH*32-1:0]            out_inst,
    input  logic                                 out_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IC_W  = $clog2(FETCH_WIDTH+1);
    localparam int NW    = $clog2(ISSUE_WIDTH+1);

    logic [31:0]      q_mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [ISSUE_WIDTH-1:0][31:0] lane_inst;
    oper_t [ISSUE_WIDTH-1:0]      d_op;
    logic [ISSUE_WIDTH-1:0][4:0]  d_ra1, d_ra2, d_wa;
    logic [ISSUE_WIDTH-1:0]       d_we, d_uimm, d_br, d_mem;
    logic [ISSUE_WIDTH-1:0]       hazard, issue;
    logic                         ok;
    logic [NW-1:0]                n_pop;
    logic                         push_en, load;
    logic [IC_W-1:0]              push_n;

    genvar k;
    generate
        for (k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
            assign lane_inst[k] = q_mem[head + PTR_W'(k)];
            id_lane_decode u_dec (
                .inst(lane_inst[k]), .op(d_op[k]), .raddr1(d_ra1[k]), .raddr2(d_ra2[k]),
                .waddr(d_wa[k]), .we(d_we[k]), .unsigned_imm(d_uimm[k]),
                .is_branch(d_br[k]), .is_mem(d_mem[k])
            );
        end
    endgenerate

    // Lane 0 never has a hazard: an invalid op still issues alone there.
    always_comb begin
        hazard = '0;
        for (int i = 1; i < ISSUE_WIDTH; i++) begin
            if (d_op[i] == OP_INVALID) hazard[i] = 1'b1;
            for (int j = 0; j < i; j++) begin
                if (d_we[j] && d_wa[j] != 5'd0 &&
                    ((d_ra1[i] != 5'd0 && d_ra1[i] == d_wa[j]) ||
                     (d_ra2[i] != 5'd0 && d_ra2[i] == d_wa[j])))
                    hazard[i] = 1'b1;
                if (d_we[j] && d_we[i] && d_wa[i] != 5'd0 && d_wa[j] == d_wa[i])
                    hazard[i] = 1'b1;
                if (d_br[j] || d_op[j] == OP_INVALID || (d_mem[j] && d_mem[i]))
                    hazard[i] = 1'b1;
            end
        end
    end

    always_comb begin
        issue = '0;
        n_pop = '0;
        ok    = 1'b1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ok       = ok & (CNT_W'(i) < count) & ~hazard[i];
            issue[i] = ok;
            n_pop    = n_pop + NW'(ok);
        end
    end

    assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
    assign push_en  = in_valid & in_ready;
    assign push_n   = push_en ? in_count : '0;
    assign load     = (out_valid == '0) | out_ready;

    always_ff @(posedge clk) begin
        if (!(rst || flush)) begin
            for (int i = 0; i < FETCH_WIDTH; i++)
                if (push_en && IC_W'(i) < in_count)
                    q_mem[tail + PTR_W'(i)] <= in_inst[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            out_valid        <= '0;
            out_op           <= '0;
            out_raddr1       <= '0;
            out_raddr2       <= '0;
            out_waddr        <= '0;
            out_we           <= '0;
            out_unsigned_imm <= '0;
            out_inst         <= '0;
        end else begin
            tail <= tail + PTR_W'(push_n);
            if (load) begin
                head             <= head + PTR_W'(n_pop);
                count            <= count + CNT_W'(push_n) - CNT_W'(n_pop);
                out_valid        <= issue;
                out_op           <= d_op;
                out_raddr1       <= d_ra1;
                out_raddr2       <= d_ra2;
                out_waddr        <= d_wa;
                out_we           <= d_we;
                out_unsigned_imm <= d_uimm;
                out_inst         <= lane_inst;
            end else begin
                count <= count + CNT_W'(push_n);
            end
        end
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// Directed bench for id_decode_queue: decode fields, group splitting, fill/wrap, flush and reset.
module tb_id_decode_queue;
    import id_decode_pkg::*;

    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_RIMM  = 6'b000001;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [63:0]       in_inst = '0;
    logic [1:0]        in_count = '0;
    logic              in_ready;
    logic [1:0]        out_valid;
    oper_t [1:0]       out_op;
    logic [1:0][4:0]   out_raddr1, out_raddr2, out_waddr;
    logic [1:0]        out_we, out_unsigned_imm;
    logic [63:0]       out_inst;
    logic              out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] fw [10];

    id_decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
        .in_count(in_count), .in_ready(in_ready), .out_valid(out_valid), .out_op(out_op),
        .out_raddr1(out_raddr1), .out_raddr2(out_raddr2), .out_waddr(out_waddr),
        .out_we(out_we), .out_unsigned_imm(out_unsigned_imm), .out_inst(out_inst),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w0, input logic [31:0] w1, input logic [1:0] n);
        in_valid = 1'b1;
        in_inst  = {w1, w0};
        in_count = n;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] iw(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        for (int i = 0; i < 10; i++) fw[i] = iw(OPC_ORI, 5'd0, 5'(i + 1), 16'(i));

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_op", 32'(out_op[0]), 32'd0);
        chk("rst_inst", out_inst[31:0], 32'd0);

        // Independent pair issues together
        out_ready = 1'b1;
        push(iw(OPC_ORI, 5'd0, 5'd1, 16'd5), iw(OPC_ADDIU, 5'd3, 5'd2, 16'd1), 2'd2);
        chk("lat_valid", 32'(out_valid), 32'd0);
        tick();
        chk("p1_valid", 32'(out_valid), 32'd3);
        chk("p1_op0", 32'(out_op[0]), 32'(OP_ORI));
        chk("p1_wa0", 32'(out_waddr[0]), 32'd1);
        chk("p1_uimm0", 32'(out_unsigned_imm[0]), 32'd1);
        chk("p1_op1", 32'(out_op[1]), 32'(OP_ADDIU));
        chk("p1_ra1_1", 32'(out_raddr1[1]), 32'd3);
        chk("p1_wa1", 32'(out_waddr[1]), 32'd2);
        chk("p1_uimm1", 32'(out_unsigned_imm[1]), 32'd0);
        chk("p1_we", 32'(out_we), 32'd3);
        tick();
        chk("p1_drain", 32'(out_valid), 32'd0);

        // RAW split
        push(iw(OPC_ADDIU, 5'd0, 5'd4, 16'd1), iw(OPC_ADDIU, 5'd4, 5'd5, 16'd2), 2'd2);
        tick();
        chk("raw_g1_valid", 32'(out_valid), 32'd1);
        chk("raw_g1_wa", 32'(out_waddr[0]), 32'd4);
        tick();
        chk("raw_g2_valid", 32'(out_valid), 32'd1);
        chk("raw_g2_ra1", 32'(out_raddr1[0]), 32'd4);
        chk("raw_g2_wa", 32'(out_waddr[0]), 32'd5);
        tick();
        chk("raw_drain", 32'(out_valid), 32'd0);

        // Branch ends the group
        push(iw(OPC_BEQ, 5'd1, 5'd2, 16'd4), iw(OPC_ORI, 5'd0, 5'd6, 16'd1), 2'd2);
        tick();
        chk("br_valid", 32'(out_valid), 32'd1);
        chk("br_op", 32'(out_op[0]), 32'(OP_BEQ));
        chk("br_we", 32'(out_we[0]), 32'd0);
        chk("br_ra2", 32'(out_raddr2[0]), 32'd2);
        tick();
        chk("br_next_valid", 32'(out_valid), 32'd1);
        chk("br_next_op", 32'(out_op[0]), 32'(OP_ORI));
        chk("br_next_wa", 32'(out_waddr[0]), 32'd6);

        // BGEZAL alone, upper word of beat must be ignored (in_count = 1)
        push(iw(OPC_RIMM, 5'd7, 5'b10001, 16'd8), 32'hFFFF_FFFF, 2'd1);
        tick();
        chk("bgezal_valid", 32'(out_valid), 32'd1);
        chk("bgezal_op", 32'(out_op[0]), 32'(OP_BGEZAL));
        chk("bgezal_wa", 32'(out_waddr[0]), 32'd31);
        chk("bgezal_we", 32'(out_we[0]), 32'd1);
        chk("bgezal_ra1", 32'(out_raddr1[0]), 32'd7);
        tick();
        chk("bgezal_drain", 32'(out_valid), 32'd0);

        // Fill with a stalled consumer, then drain across the pointer wrap
        out_ready = 1'b0;
        push(fw[0], fw[1], 2'd2);
        push(fw[2], fw[3], 2'd2);
        chk("fill_valid", 32'(out_valid), 32'd3);
        chk("fill_inst0", out_inst[31:0], fw[0]);
        for (int b = 2; b < 5; b++) begin
            push(fw[2*b], fw[2*b+1], 2'd2);
            chk("hold_inst0", out_inst[31:0], fw[0]);
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(dut.count), 32'd8);
        push(iw(OPC_ORI, 5'd0, 5'd20, 16'd0), iw(OPC_ORI, 5'd0, 5'd21, 16'd0), 2'd2);
        chk("full_ready2", 32'(in_ready), 32'd0);
        chk("hold_inst1", out_inst[63:32], fw[1]);
        chk("hold_valid", 32'(out_valid), 32'd3);
        out_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("wrap_valid", 32'(out_valid), 32'd3);
            chk("wrap_inst0", out_inst[31:0], fw[2*g+2]);
            chk("wrap_inst1", out_inst[63:32], fw[2*g+3]);
        end
        tick();
        chk("wrap_drain", 32'(out_valid), 32'd0);

        // Invalid opcode issues alone; then LW; LW+SW split
        push(32'hFC00_0000, iw(OPC_LW, 5'd8, 5'd9, 16'd4), 2'd2);
        tick();
        chk("inv_valid", 32'(out_valid), 32'd1);
        chk("inv_op", 32'(out_op[0]), 32'(OP_INVALID));
        chk("inv_we", 32'(out_we[0]), 32'd0);
        tick();
        chk("lw_valid", 32'(out_valid), 32'd1);
        chk("lw_op", 32'(out_op[0]), 32'(OP_LW));
        chk("lw_ra1", 32'(out_raddr1[0]), 32'd8);
        chk("lw_ra2", 32'(out_raddr2[0]), 32'd9);
        chk("lw_we", 32'(out_we[0]), 32'd1);
        push(iw(OPC_LW, 5'd11, 5'd10, 16'd0), iw(OPC_SW, 5'd13, 5'd12, 16'd0), 2'd2);
        tick();
        chk("mem_g1_valid", 32'(out_valid), 32'd1);
        chk("mem_g1_op", 32'(out_op[0]), 32'(OP_LW));
        tick();
        chk("mem_g2_valid", 32'(out_valid), 32'd1);
        chk("mem_g2_op", 32'(out_op[0]), 32'(OP_SW));
        chk("mem_g2_we", 32'(out_we[0]), 32'd0);
        tick();

        // flush with enqueue and a loaded output stage
        out_ready = 1'b1;
        push(fw[0], fw[1], 2'd2);
        tick();
        chk("fl_pre_valid", 32'(out_valid), 32'd3);
        out_ready = 1'b0;
        push(fw[2], fw[3], 2'd2);
        flush = 1'b1;
        push(fw[4], fw[5], 2'd2);
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_count", 32'(dut.count), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl_after", 32'(out_valid), 32'd0);

        // reset mid-stream
        out_ready = 1'b1;
        push(fw[6], fw[7], 2'd2);
        tick();
        chk("rs_pre_valid", 32'(out_valid), 32'd3);
        out_ready = 1'b0;
        push(fw[8], fw[9], 2'd2);
        rst = 1'b1;
        push(fw[0], fw[1], 2'd2);
        rst = 1'b0;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_count", 32'(dut.count), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        chk("rs_inst", out_inst[31:0], 32'd0);
        tick();
        chk("rs_after", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
